// File: rtl/apb_uart_lite_pkg.sv
// ---------------------------------------------------------------------------
// apb_uart_pkg
//   Shared definitions for the APB UART-lite slice: register byte offsets,
//   STATUS / CONTROL bit positions, the common tx/rx FSM state type and the
//   bit-period helper that both FSMs use.
// ---------------------------------------------------------------------------
package apb_uart_pkg;

   // Register byte offsets inside the 16-byte window (only [3:2] decode).
   localparam logic [3:0] ADDR_DATA    = 4'h0;
   localparam logic [3:0] ADDR_STATUS  = 4'h4;
   localparam logic [3:0] ADDR_DIVISOR = 4'h8;
   localparam logic [3:0] ADDR_CONTROL = 4'hC;

   // STATUS bits
   localparam int ST_RX_VALID  = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_TX_FULL   = 2;
   localparam int ST_RX_OVR    = 3;
   localparam int ST_FRAME_ERR = 4;
   localparam int ST_TX_OVR    = 5;

   // CONTROL bits
   localparam int CT_LOOPBACK  = 0;
   localparam int CT_IE_RX     = 1;
   localparam int CT_IE_TX     = 2;
   localparam int CT_CLR_ERR   = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   // Bit period in PCLK cycles; 0 and 1 are too short to time a bit, so
   // they behave as 2.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd2 : d;
   endfunction

endpackage

// File: rtl/apb_uart_lite_rx.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   8N1 receiver: 2-flop synchronizer, falling-edge start detect, mid-bit
//   re-check of the start bit, then 8 data bits LSB first and the stop bit,
//   each sampled one bit period apart.
// Ports:
//   PCLK, PRESETn  clock / synchronous active-low reset
//   rx_in          asynchronous serial input (idle high)
//   divisor        PCLK cycles per bit (raw register value)
//   rx_byte        last assembled byte, stable while byte_valid is high
//   byte_valid     1-cycle pulse: frame with good stop bit received
//   frame_err      1-cycle pulse: frame with low stop bit received
// ---------------------------------------------------------------------------
module uart_rx_core
   import apb_uart_pkg::*;
(
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        rx_in,
   input  logic [15:0] divisor,
   output logic [7:0]  rx_byte,
   output logic        byte_valid,
   output logic        frame_err
);

   logic        sync1, sync2, prev;
   uart_state_e state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic [2:0]  bit_idx, bit_idx_nx;
   logic [7:0]  shift, shift_nx;
   logic        bv_nx, fe_nx;
   logic [15:0] bit_len;

   // Sampled at every reload, so a DIVISOR change lands on a bit boundary.
   assign bit_len = eff_div(divisor);
   assign rx_byte = shift;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         prev       <= 1'b1;
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rx_in;
         sync2      <= sync1;
         prev       <= sync2;
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_idx    <= bit_idx_nx;
         shift      <= shift_nx;
         byte_valid <= bv_nx;
         frame_err  <= fe_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      bv_nx      = 1'b0;
      fe_nx      = 1'b0;
      case (state)
         S_IDLE: begin
            if (prev && !sync2) begin
               state_nx = S_START;
               // half period to the centre of the start bit
               cnt_nx   = (bit_len >> 1) - 16'd1;
            end
         end
         S_START: begin
            if (cnt == 16'd0) begin
               if (sync2) begin
                  state_nx = S_IDLE;       // too short to be a start bit
               end else begin
                  state_nx   = S_DATA;
                  bit_idx_nx = 3'd0;
                  cnt_nx     = bit_len - 16'd1;
               end
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt == 16'd0) begin
               shift_nx = {sync2, shift[7:1]};
               cnt_nx   = bit_len - 16'd1;
               if (bit_idx == 3'd7) state_nx = S_STOP;
               else                 bit_idx_nx = bit_idx + 3'd1;
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt == 16'd0) begin
               state_nx = S_IDLE;
               if (sync2) bv_nx = 1'b1;
               else       fe_nx = 1'b1;
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: rtl/apb_uart_lite.sv
// ---------------------------------------------------------------------------
// apb_uart_lite
//   APB3 completer with a minimal 8N1 UART: one TX holding register feeding
//   a TX shifter FSM, one RX holding register fed by uart_rx_core.
// Ports:
//   PCLK, PRESETn        clock / synchronous active-low reset
//   PSEL PADDR PENABLE   APB3 request (zero wait states, PREADY tied 1)
//   PWRITE PWDATA
//   PRDATA               registered in setup phase, valid in access phase
//   PREADY, PSLVERR      PSLVERR only for a write to STATUS
//   IRQ                  (rx_valid & ie_rx) | (tx_empty & ie_tx)
//   TXD / RXD            serial out (idle high) / asynchronous serial in
// Register map: 0x0 DATA, 0x4 STATUS, 0x8 DIVISOR, 0xC CONTROL.
// ---------------------------------------------------------------------------
module apb_uart_lite
   import apb_uart_pkg::*;
#(
   parameter logic [15:0] P_ADDR_START = 16'h0000,
   parameter logic [15:0] P_DIV_RESET  = 16'd434
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic [31:0] PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        IRQ,
   output logic        TXD,
   input  logic        RXD
);

   // ---------------- APB decode ----------------
   logic       hit, setup_ph, wr_acc, rd_acc;
   logic [3:0] roff;
   logic       wr_data, wr_div, wr_ctrl, wr_stat, pop, clr_err;

   assign hit      = (PADDR[31:4] == {P_ADDR_START, 12'h000});
   assign roff     = {PADDR[3:2], 2'b00};
   assign setup_ph = PSEL & ~PENABLE;
   assign wr_acc   = PSEL & PENABLE &  PWRITE & hit;
   assign rd_acc   = PSEL & PENABLE & ~PWRITE & hit;
   assign wr_data  = wr_acc & (roff == ADDR_DATA);
   assign wr_stat  = wr_acc & (roff == ADDR_STATUS);
   assign wr_div   = wr_acc & (roff == ADDR_DIVISOR);
   assign wr_ctrl  = wr_acc & (roff == ADDR_CONTROL);
   assign pop      = rd_acc & (roff == ADDR_DATA);
   assign clr_err  = wr_ctrl & PWDATA[CT_CLR_ERR];

   assign PREADY  = 1'b1;
   assign PSLVERR = wr_stat;

   logic unused_bits;
   assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

   // ---------------- registers / flags ----------------
   logic [15:0] divisor;
   logic        loopback, ie_rx, ie_tx;
   logic [7:0]  hold_data;
   logic        hold_full;
   logic [7:0]  rx_byte;
   logic        rx_valid, rx_ovr, frm_err, tx_ovr;
   logic        tx_empty;

   // ---------------- TX FSM state ----------------
   uart_state_e tx_state, tx_state_nx;
   logic [15:0] tx_cnt, tx_cnt_nx;
   logic [2:0]  tx_bit, tx_bit_nx;
   logic [7:0]  tx_shift, tx_shift_nx;
   logic        txd_q, txd_nx;
   logic        tx_take;
   logic [15:0] tx_len;

   assign tx_len   = eff_div(divisor);
   assign tx_empty = ~hold_full & (tx_state == S_IDLE);
   assign TXD      = txd_q;

   // ---------------- RX ----------------
   logic       rx_src, rx_done, rx_ferr;
   logic [7:0] rx_core_byte;

   assign rx_src = loopback ? txd_q : RXD;

   uart_rx_core u_rx (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .rx_in      (rx_src),
      .divisor    (divisor),
      .rx_byte    (rx_core_byte),
      .byte_valid (rx_done),
      .frame_err  (rx_ferr)
   );

   assign IRQ = (rx_valid & ie_rx) | (tx_empty & ie_tx);

   // ---------------- read mux ----------------
   logic [31:0] status, rd_mux;

   always_comb begin
      status               = '0;
      status[ST_RX_VALID]  = rx_valid;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_TX_FULL]   = hold_full;
      status[ST_RX_OVR]    = rx_ovr;
      status[ST_FRAME_ERR] = frm_err;
      status[ST_TX_OVR]    = tx_ovr;
   end

   always_comb begin
      rd_mux = '0;
      case (roff)
         ADDR_DATA:    rd_mux = {24'h0, rx_byte};
         ADDR_STATUS:  rd_mux = status;
         ADDR_DIVISOR: rd_mux = {16'h0, divisor};
         ADDR_CONTROL: begin
            rd_mux[CT_LOOPBACK] = loopback;
            rd_mux[CT_IE_RX]    = ie_rx;
            rd_mux[CT_IE_TX]    = ie_tx;
         end
         default:      rd_mux = '0;
      endcase
   end

   // ---------------- register file ----------------
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         divisor   <= P_DIV_RESET;
         loopback  <= 1'b0;
         ie_rx     <= 1'b0;
         ie_tx     <= 1'b0;
         hold_data <= '0;
         hold_full <= 1'b0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         rx_ovr    <= 1'b0;
         frm_err   <= 1'b0;
         tx_ovr    <= 1'b0;
         PRDATA    <= '0;
      end else begin
         if (wr_div) divisor <= PWDATA[15:0];
         if (wr_ctrl) begin
            loopback <= PWDATA[CT_LOOPBACK];
            ie_rx    <= PWDATA[CT_IE_RX];
            ie_tx    <= PWDATA[CT_IE_TX];
         end
         // The FSM only takes the hold when it is full, and a write only
         // loads it when empty, so the two never collide.
         if (tx_take) begin
            hold_full <= 1'b0;
         end else if (wr_data && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= PWDATA[7:0];
         end
         // A pop in the same cycle as a completed frame frees the slot.
         if (rx_done && (!rx_valid || pop)) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_core_byte;
         end else if (pop) begin
            rx_valid <= 1'b0;
         end
         // New error events win over a simultaneous clear.
         rx_ovr  <= (rx_ovr  & ~clr_err) | (rx_done & rx_valid & ~pop);
         frm_err <= (frm_err & ~clr_err) | rx_ferr;
         tx_ovr  <= (tx_ovr  & ~clr_err) | (wr_data & hold_full);
         if (setup_ph) PRDATA <= hit ? rd_mux : 32'h0;
      end
   end

   // ---------------- TX FSM ----------------
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         txd_q    <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_bit   <= tx_bit_nx;
         tx_shift <= tx_shift_nx;
         txd_q    <= txd_nx;
      end
   end

   // txd_q is the registered line value for the bit being entered, so each
   // bit spans exactly tx_len cycles from the edge that starts it.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_bit_nx   = tx_bit;
      tx_shift_nx = tx_shift;
      txd_nx      = txd_q;
      tx_take     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            txd_nx = 1'b1;
            if (hold_full) begin
               tx_state_nx = S_START;
               tx_shift_nx = hold_data;
               tx_cnt_nx   = tx_len - 16'd1;
               tx_take     = 1'b1;
               txd_nx      = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt == 16'd0) begin
               tx_state_nx = S_DATA;
               tx_bit_nx   = 3'd0;
               tx_cnt_nx   = tx_len - 16'd1;
               txd_nx      = tx_shift[0];
            end else begin
               tx_cnt_nx = tx_cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (tx_cnt == 16'd0) begin
               tx_cnt_nx = tx_len - 16'd1;
               if (tx_bit == 3'd7) begin
                  tx_state_nx = S_STOP;
                  txd_nx      = 1'b1;
               end else begin
                  tx_bit_nx = tx_bit + 3'd1;
                  txd_nx    = tx_shift[tx_bit + 3'd1];
               end
            end else begin
               tx_cnt_nx = tx_cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (tx_cnt == 16'd0) begin
               if (hold_full) begin
                  // back-to-back: no idle bit between frames
                  tx_state_nx = S_START;
                  tx_shift_nx = hold_data;
                  tx_cnt_nx   = tx_len - 16'd1;
                  tx_take     = 1'b1;
                  txd_nx      = 1'b0;
               end else begin
                  tx_state_nx = S_IDLE;
                  txd_nx      = 1'b1;
               end
            end else begin
               tx_cnt_nx = tx_cnt - 16'd1;
            end
         end
         default: tx_state_nx = S_IDLE;
      endcase
   end

endmodule
